// File: rtl/axi_types_pkg.sv
// rtl/axi_types_pkg.sv - AXI encodings and burst engine state type shared by the read and write engines
//
// Contents:
//   AXI_BURST_FIXED/INCR/WRAP : arburst encodings
//   axi_resp_e                : OKAY, EXOKAY, SLVERR, DECERR response codes
//   AXI_4KB                   : bursts must not cross this byte boundary
//   engine_state_e            : IDLE, ADDR, DATA, DONE
//   axi_size_log2             : log2 of bytes per beat for a data width in bits
package axi_types_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam int AXI_4KB = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } engine_state_e;

  function automatic int axi_size_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// rtl/axi_burst_len_calc.sv - beats for the next INCR burst and its arlen/awlen encoding
//
// Ports:
//   addr_lo   in  12         low bits of the burst start byte address (beat aligned)
//   remaining in  RemWidth   words still to move (callers only use the result when >= 1)
//   beats     out 9          min(remaining, MaxBurstLen, words left before the next 4KB line)
//   arlen     out 8          beats - 1
module axi_burst_len_calc
  import axi_types_pkg::*;
#(
  parameter int RemWidth    = 8,
  parameter int MaxBurstLen = 16,
  parameter int ByteShift   = 2
) (
  input  logic [11:0]         addr_lo,
  input  logic [RemWidth-1:0] remaining,
  output logic [8:0]          beats,
  output logic [7:0]          arlen
);

  localparam logic [31:0] MAX_BEATS = 32'(MaxBurstLen);
  localparam logic [31:0] LINE_BYTES = 32'(AXI_4KB);

  logic [31:0] to_4kb;
  logic [31:0] rem_ext;
  logic [31:0] pick;

  always_comb begin
    to_4kb  = (LINE_BYTES - {20'd0, addr_lo}) >> ByteShift;
    rem_ext = 32'(remaining);
    pick    = rem_ext;
    if (MAX_BEATS < pick) pick = MAX_BEATS;
    if (to_4kb < pick) pick = to_4kb;
    beats = pick[8:0];
    arlen = 8'(pick - 32'd1);
  end

endmodule

// File: rtl/axi_burst_read_engine.sv
// rtl/axi_burst_read_engine.sv - fetches data_size words over AXI INCR bursts into a local buffer
//
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   start_valid/start_ready         start handshake; data_ptr, data_size, axi_offset captured on it
//   done_valid/done_ready/done_error completion handshake; error set by bad rresp or rlast mismatch
//   buffer_addr/wdata/ce/we         single-port buffer write port, active only on R beats
//   ar*                             AXI read address channel (one outstanding burst)
//   r*                              AXI read data channel (rid ignored)
module axi_burst_read_engine
  import axi_types_pkg::*;
#(
  parameter int BufferDataWidth = 32,
  parameter int BufferAddrWidth = 8,
  parameter int AXIAddrWidth    = 32,
  parameter int AXIDataWidth    = 32,
  parameter int AXIIDWidth      = 1,
  parameter int AXIMaxBurstLen  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [BufferAddrWidth-1:0] data_ptr,
  input  logic [BufferAddrWidth-1:0] data_size,
  input  logic [AXIAddrWidth-1:0]    axi_offset,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic                       done_error,
  output logic [BufferAddrWidth-1:0] buffer_addr,
  output logic [BufferDataWidth-1:0] buffer_wdata,
  output logic                       buffer_ce,
  output logic                       buffer_we,
  output logic [AXIAddrWidth-1:0]    araddr,
  output logic [AXIIDWidth-1:0]      arid,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [AXIDataWidth-1:0]    rdata,
  input  logic [AXIIDWidth-1:0]      rid,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int BYTE_SHIFT = axi_size_log2(AXIDataWidth);
  localparam logic [AXIAddrWidth-1:0] ALIGN_MASK = ~AXIAddrWidth'((1 << BYTE_SHIFT) - 1);

  engine_state_e state_q, state_d;

  logic [AXIAddrWidth-1:0]    addr_q;
  logic [BufferAddrWidth-1:0] buf_ptr_q;
  logic [BufferAddrWidth-1:0] remaining_q;
  logic [8:0]                 beat_cnt_q;
  logic [8:0]                 burst_beats_q;
  logic                       err_q;
  logic [AXIAddrWidth-1:0]    araddr_q;
  logic [7:0]                 arlen_q;

  logic                       start_fire;
  logic                       ar_fire;
  logic                       r_fire;
  logic                       final_beat;
  logic                       enter_addr;
  logic [AXIAddrWidth-1:0]    start_addr;
  logic [AXIAddrWidth-1:0]    burst_bytes;
  logic [AXIAddrWidth-1:0]    calc_addr;
  logic [BufferAddrWidth-1:0] calc_rem;
  logic [8:0]                 calc_beats;
  logic [7:0]                 calc_arlen;
  logic                       unused_rid;

  assign unused_rid = ^rid;

  assign start_fire  = start_valid && start_ready;
  assign ar_fire     = arvalid && arready;
  assign r_fire      = rvalid && rready;
  assign final_beat  = r_fire && (beat_cnt_q == 9'd1);
  assign start_addr  = axi_offset & ALIGN_MASK;
  assign burst_bytes = AXIAddrWidth'(burst_beats_q) << BYTE_SHIFT;

  // The AR fields are registered on the way into ADDR, so the length
  // calculator looks at the values addr/remaining are about to take.
  always_comb begin
    if (state_q == IDLE) begin
      calc_addr = start_addr;
      calc_rem  = data_size;
    end else begin
      calc_addr = addr_q + burst_bytes;
      calc_rem  = remaining_q - BufferAddrWidth'(1);
    end
  end

  axi_burst_len_calc #(
    .RemWidth   (BufferAddrWidth),
    .MaxBurstLen(AXIMaxBurstLen),
    .ByteShift  (BYTE_SHIFT)
  ) u_len_calc (
    .addr_lo  (calc_addr[11:0]),
    .remaining(calc_rem),
    .beats    (calc_beats),
    .arlen    (calc_arlen)
  );

  assign enter_addr = (state_q != ADDR) && (state_d == ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_fire) state_d = (data_size == '0) ? DONE : ADDR;
      ADDR: if (ar_fire) state_d = DATA;
      // The burst closes on the beat count; rlast only feeds the error flag.
      DATA: if (final_beat) state_d = (remaining_q == BufferAddrWidth'(1)) ? DONE : ADDR;
      DONE: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q        <= '0;
      buf_ptr_q     <= '0;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      burst_beats_q <= '0;
      err_q         <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
    end else begin
      if (enter_addr) begin
        araddr_q      <= calc_addr;
        arlen_q       <= calc_arlen;
        burst_beats_q <= calc_beats;
      end
      case (state_q)
        IDLE: begin
          if (start_fire) begin
            addr_q      <= start_addr;
            buf_ptr_q   <= data_ptr;
            remaining_q <= data_size;
            err_q       <= 1'b0;
          end
        end
        ADDR: begin
          if (ar_fire) beat_cnt_q <= burst_beats_q;
        end
        DATA: begin
          if (r_fire) begin
            buf_ptr_q   <= buf_ptr_q + BufferAddrWidth'(1);
            remaining_q <= remaining_q - BufferAddrWidth'(1);
            beat_cnt_q  <= beat_cnt_q - 9'd1;
            if (rresp != OKAY) err_q <= 1'b1;
            if (rlast != (beat_cnt_q == 9'd1)) err_q <= 1'b1;
            if (beat_cnt_q == 9'd1) addr_q <= addr_q + burst_bytes;
          end
        end
        DONE: begin
          if (done_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    // start_ready is also gated by reset so it reads 0 while reset is held.
    start_ready  = (state_q == IDLE) && reset;
    arvalid      = (state_q == ADDR);
    rready       = (state_q == DATA);
    done_valid   = (state_q == DONE);
    done_error   = (state_q == DONE) && err_q;
    buffer_ce    = (state_q == DATA) && rvalid;
    buffer_we    = (state_q == DATA) && rvalid;
    buffer_addr  = buf_ptr_q;
    buffer_wdata = rdata;
    araddr       = araddr_q;
    arlen        = arlen_q;
    arid         = '0;
    arsize       = 3'(BYTE_SHIFT);
    arburst      = AXI_BURST_INCR;
  end

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// tb/tb_axi_burst_read_engine.sv - scoreboard bench with a stalling AXI read slave for axi_burst_read_engine
module tb_axi_burst_read_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [7:0]  data_ptr = '0;
  logic [7:0]  data_size = '0;
  logic [31:0] axi_offset = '0;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic        done_error;
  logic [7:0]  buffer_addr;
  logic [31:0] buffer_wdata;
  logic        buffer_ce;
  logic        buffer_we;
  logic [31:0] araddr;
  logic [0:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [0:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi_burst_read_engine #(
    .BufferDataWidth(32), .BufferAddrWidth(8), .AXIAddrWidth(32),
    .AXIDataWidth(32), .AXIIDWidth(1), .AXIMaxBurstLen(16)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
    .done_valid(done_valid), .done_ready(done_ready), .done_error(done_error),
    .buffer_addr(buffer_addr), .buffer_wdata(buffer_wdata),
    .buffer_ce(buffer_ce), .buffer_we(buffer_we),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234 ^ {a[15:0], a[31:16]};
  endfunction

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

  ar_t  exp_ar[$];
  wr_t  exp_wr[$];
  bit   exp_done[$];
  logic [31:0] tbuf [256];

  int ar_count = 0;
  int wr_count = 0;
  int done_count = 0;

  // Reference: chop the transfer into bursts of at most 16 beats that never cross 4KB.
  task automatic model_xfer(input logic [7:0] p, input int size, input logic [31:0] off, input bit err);
    logic [31:0] a;
    logic [7:0]  bp;
    int rem, n, to4k;
    a   = off - (off % 4);
    bp  = p;
    rem = size;
    while (rem > 0) begin
      n = rem;
      if (n > 16) n = 16;
      to4k = (4096 - int'(a % 4096)) / 4;
      if (n > to4k) n = to4k;
      exp_ar.push_back('{addr: a, len: 8'(n - 1)});
      for (int k = 0; k < n; k++) begin
        exp_wr.push_back('{addr: bp, data: mem_word(a + 32'(4 * k))});
        bp = bp + 8'd1;
      end
      a   = a + 32'(4 * n);
      rem = rem - n;
    end
    exp_done.push_back(err);
  endtask

  // Slave state
  bit          stall_en = 0;
  int          err_beat = -1;
  int          rlast_bad_beat = -1;
  int          g_beat = 0;
  bit          s_busy = 0;
  logic [31:0] s_addr = '0;
  int          s_left = 0;
  int          ar_stall = 0;
  int          r_stall = 0;
  bit          rst_s = 0;
  bit          ar_fire_s = 0;
  bit          r_fire_s = 0;
  logic [31:0] ar_addr_s = '0;
  logic [7:0]  ar_len_s = '0;

  always @(negedge clk) begin
    rst_s     = reset;
    ar_fire_s = arvalid && arready;
    r_fire_s  = rvalid && rready;
    ar_addr_s = araddr;
    ar_len_s  = arlen;
  end

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    forever begin
      @(posedge clk); #1;
      rid = 1'($urandom_range(0, 1));
      if (!rst_s) begin
        s_busy = 0; arready = 1'b0; rvalid = 1'b0; ar_stall = 0; r_stall = 0;
      end else begin
        if (r_fire_s) begin
          s_left--;
          s_addr = s_addr + 32'd4;
          g_beat++;
          if (s_left == 0) s_busy = 0;
        end
        if (ar_fire_s) begin
          s_busy = 1;
          s_addr = ar_addr_s;
          s_left = int'(ar_len_s) + 1;
        end
        if (s_busy) arready = 1'b0;
        else if (ar_stall > 0) begin ar_stall--; arready = 1'b0; end
        else if (stall_en && $urandom_range(0, 1) == 1) begin
          ar_stall = $urandom_range(0, 4); arready = 1'b0;
        end else arready = 1'b1;
        if (!s_busy) rvalid = 1'b0;
        else if (r_stall > 0) begin r_stall--; rvalid = 1'b0; end
        else if (stall_en && $urandom_range(0, 1) == 1) begin
          r_stall = $urandom_range(0, 4); rvalid = 1'b0;
        end else begin
          rvalid = 1'b1;
          rdata  = mem_word(s_addr);
          rresp  = (g_beat == err_beat) ? 2'b10 : 2'b00;
          rlast  = (s_left == 1) ^ (g_beat == rlast_bad_beat);
        end
      end
    end
  end

  // Monitor / scoreboard
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_wait && arvalid) begin
        check("ar_addr_stable", araddr, prev_addr);
        check("ar_len_stable", arlen, prev_len);
      end
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (arvalid && arready) begin
        ar_t e;
        ar_count++;
        if (exp_ar.size() == 0) fail_event("unexpected_ar");
        else begin
          e = exp_ar.pop_front();
          check("ar_addr", araddr, e.addr);
          check("ar_len", arlen, e.len);
          check("ar_size", arsize, 3'd2);
          check("ar_burst", arburst, 2'b01);
        end
      end
      if (buffer_ce) begin
        wr_t w;
        wr_count++;
        check("buf_we", buffer_we, 1'b1);
        if (exp_wr.size() == 0) fail_event("unexpected_buffer_write");
        else begin
          w = exp_wr.pop_front();
          check("buf_addr", buffer_addr, w.addr);
          check("buf_data", buffer_wdata, w.data);
        end
        tbuf[buffer_addr] = buffer_wdata;
      end
      if (done_valid && done_ready) begin
        done_count++;
        if (exp_done.size() == 0) fail_event("unexpected_done");
        else check("done_error", done_error, exp_done.pop_front());
      end
    end else prev_wait = 0;
  end

  task automatic start_xfer(input logic [7:0] p, input logic [7:0] s, input logic [31:0] o);
    int t;
    @(posedge clk); #1;
    data_ptr = p; data_size = s; axi_offset = o; start_valid = 1'b1;
    @(negedge clk);
    t = 0;
    while (!start_ready && t < 300) begin @(negedge clk); t++; end
    if (!start_ready) fail_event("start_ready_timeout");
    @(posedge clk); #1;
    start_valid = 1'b0;
    data_ptr = 8'($urandom); data_size = 8'($urandom); axi_offset = $urandom;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_count < target && t < 4000) begin @(negedge clk); t++; end
    if (done_count < target) fail_event("done_timeout");
  endtask

  task automatic run_xfer(input logic [7:0] p, input logic [7:0] s, input logic [31:0] o, input bit err);
    int target, wr0;
    model_xfer(p, int'(s), o, err);
    g_beat = 0;
    target = done_count + 1;
    wr0 = wr_count;
    start_xfer(p, s, o);
    wait_done(target);
    check("write_count", 64'(wr_count - wr0), 64'(s));
    check("queues_drained", 64'(exp_ar.size() + exp_wr.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0, t;
    logic [31:0] o;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", start_ready, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_buffer_ce", buffer_ce, 1'b0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arlen", arlen, 8'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("idle_start_ready", start_ready, 1'b1);

    // Single word
    ar0 = ar_count;
    run_xfer(8'd5, 8'd1, 32'h40, 1'b0);
    check("single_buf5", tbuf[5], 32'hDEADBEEF);
    check("single_ar_count", 64'(ar_count - ar0), 64'd1);

    // Multi-burst: 16/16/8
    ar0 = ar_count;
    run_xfer(8'd0, 8'd40, 32'h0, 1'b0);
    check("multi_ar_count", 64'(ar_count - ar0), 64'd3);

    // 4KB crossing, unaligned low bits ignored
    run_xfer(8'd100, 8'd6, 32'hFF9, 1'b0);

    // Zero length with done backpressure
    ar0 = ar_count;
    done_ready = 1'b0;
    exp_done.push_back(1'b0);
    start_xfer(8'd3, 8'd0, 32'h100);
    t = 0;
    while (!done_valid && t < 2) begin @(negedge clk); t++; end
    check("zero_done_quick", done_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("zero_done_held", done_valid, 1'b1);
      check("zero_start_ready_low", start_ready, 1'b0);
    end
    done_ready = 1'b1;
    wait_done(done_count + 1);
    check("zero_no_ar", 64'(ar_count - ar0), 64'd0);

    // Stalls and buffer pointer wrap
    stall_en = 1;
    run_xfer(8'd250, 8'd12, 32'h1230, 1'b0);
    check("wrap_buf255", tbuf[255], mem_word(32'h1230 + 32'd20));
    check("wrap_buf0", tbuf[0], mem_word(32'h1230 + 32'd24));
    stall_en = 0;

    // SLVERR on the third beat still writes everything
    err_beat = 2;
    run_xfer(8'd20, 8'd8, 32'h800, 1'b1);
    err_beat = -1;

    // Early rlast, then missing rlast
    rlast_bad_beat = 1;
    run_xfer(8'd30, 8'd4, 32'h900, 1'b1);
    rlast_bad_beat = 3;
    run_xfer(8'd30, 8'd4, 32'h900, 1'b1);
    rlast_bad_beat = -1;
    run_xfer(8'd40, 8'd3, 32'hA00, 1'b0);

    // Reset in the middle of DATA
    model_xfer(8'd60, 30, 32'h2000, 1'b0);
    g_beat = 0;
    t = wr_count;
    start_xfer(8'd60, 8'd30, 32'h2000);
    ar0 = 0;
    while (wr_count < t + 3 && ar0 < 500) begin @(negedge clk); ar0++; end
    if (wr_count < t + 3) fail_event("mid_reset_no_data");
    @(posedge clk); #1 reset = 1'b0;
    exp_ar.delete(); exp_wr.delete(); exp_done.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_done_valid", done_valid, 1'b0);
    check("mid_rst_start_ready", start_ready, 1'b1);
    run_xfer(8'd70, 8'd18, 32'h3004, 1'b0);

    // Randomized transfers, including address wrap through 0
    run_xfer(8'd200, 8'd20, 32'hFFFF_FFE0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      o = $urandom;
      if (i % 2 == 1) o[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      stall_en = $urandom_range(0, 1);
      run_xfer(8'($urandom), 8'($urandom_range(1, 70)), o, 1'b0);
    end
    stall_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_engine.md
Name: axi_burst_read_engine

Overview:
- Read-side counterpart of the AXI burst write engine.
- On a start handshake, fetches `data_size` words from AXI memory starting at byte address `axi_offset`, using INCR bursts on the AR/R channels.
- Writes each returned beat into a local single-port data buffer at `data_ptr`, `data_ptr`+1, and so on.
- Signals completion through a done handshake. Sits between an AXI read-capable slave (memory or BFM) and on-chip buffers that feed the tracer.

Parameters:
- BufferDataWidth, 32, buffer word width; must equal AXIDataWidth.
- BufferAddrWidth, 8, buffer address width; also the width of `data_size`.
- AXIAddrWidth, 32, AXI byte-address width.
- AXIDataWidth, 32, AXI data width (bits, power of two, ≥8).
- AXIIDWidth, 1, AXI ID width.
- AXIMaxBurstLen, 16, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- start_valid  in  1  request to start a transfer.
- start_ready  out  1  engine idle; arguments are captured on start_valid&&start_ready.
- data_ptr  in  BufferAddrWidth  first buffer word address.
- data_size  in  BufferAddrWidth  number of words to read.
- axi_offset  in  AXIAddrWidth  AXI start byte address.
- done_valid  out  1  transfer complete.
- done_ready  in  1  consumer accepts done.
- done_error  out  1  valid with done_valid; 1 if any rresp≠OKAY or an rlast mismatch occurred.
- buffer_addr  out  BufferAddrWidth  buffer write address.
- buffer_wdata  out  BufferDataWidth  buffer write data.
- buffer_ce  out  1  buffer enable.
- buffer_we  out  1  buffer write enable.
- araddr  out  AXIAddrWidth  burst byte address.
- arid  out  AXIIDWidth  constant 0.
- arlen  out  8  beats−1.
- arsize  out  3  log2(AXIDataWidth/8).
- arburst  out  2  constant INCR (2'b01).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  AXIDataWidth  read data.
- rid  in  AXIIDWidth  ignored.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. Outputs are: start_ready=0 during reset and 1 in IDLE afterwards; done_valid=0; done_error=0; arvalid=0; rready=0; buffer_ce=0; buffer_we=0; araddr=0; arlen=0.
- Reset mid-operation: the engine aborts with no done. Reset the slave alongside.
- IDLE state:
  - start_ready=1.
  - On start handshake, latch buf_ptr=data_ptr, remaining=data_size, and addr=axi_offset with the low log2(AXIDataWidth/8) bits forced to 0.
  - Go to DONE if data_size==0 (no AXI traffic, done_error=0); otherwise go to ADDR.
- ADDR state:
  - Compute beats = min(remaining, AXIMaxBurstLen, words_to_4KB).
  - words_to_4KB = (4096 − addr[11:0]) >> log2(AXIDataWidth/8).
  - Drive arvalid=1, araddr=addr, arlen=beats−1. These are registered and stable while arvalid is high.
  - On arready, record the beat count, then go to DATA. ADDR is never entered with remaining==0.
- DATA state:
  - rready=1.
  - Each rvalid&&rready: same cycle buffer_ce=1, buffer_we=1, buffer_addr=buf_ptr, buffer_wdata=rdata.
  - Then buf_ptr+1 (wraps mod 2^BufferAddrWidth), remaining−1, and beat count−1.
  - rresp≠2'b00 sets a sticky error. Its data is still written.
  - rlast must coincide with the final beat of the burst. Early or missing rlast sets a sticky error; the burst ends on the beat count, not on rlast.
  - After the final beat, addr += beats×(AXIDataWidth/8). Go to ADDR if remaining>0, else to DONE.
- Outstanding bursts: exactly one; the next AR is issued only after the previous burst's last beat. Minimum gap is one cycle from the last R beat to the next arvalid.
- DONE state:
  - done_valid=1, done_error = sticky error; both held until done_ready.
  - On done_ready, go to IDLE, clear the error, start_ready=1 next cycle. Back-to-back starts are allowed.
- Buffer port: buffer_ce=buffer_we=0 in all states except during R beats. No reads are issued.
- Inputs data_ptr, data_size and axi_offset are ignored except at the start handshake.
- Address arithmetic is modulo 2^AXIAddrWidth.

Decomposition:
- Package axi_types_pkg:
  - burst encodings: AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP;
  - response codes: OKAY, EXOKAY, SLVERR, DECERR;
  - AXI_4KB=4096;
  - engine state enum: IDLE, ADDR, DATA, DONE.
- The package is shared with the write engine.
- One sub-module, axi_burst_len_calc: combinational min(remaining, max, to-4KB) and the arlen encoding, reused by the write engine.

Test Plan:
- Single word: data_ptr=5, axi_offset=0x40, size=1; memory[0x40]=0xDEADBEEF → one AR with arlen=0; buffer[5]=0xDEADBEEF; done_error=0.
- Multi-burst: ptr=0, offset=0x0, size=40 → ARs at 0x0/0x40/0x80 with arlen 15/15/7; buffer[0..39] matches memory; exactly 40 buffer writes.
- 4KB crossing: offset=0xFF8, size=6 → AR 0xFF8 arlen=1, then AR 0x1000 arlen=3; all 6 words correct.
- Zero length plus backpressure: size=0 → no arvalid and done_valid within 2 cycles. With done_ready held low for 10 cycles, done_valid stays 1 and start_ready stays 0.
- Stalls and wrap: ptr=250, size=12, random AR/R stalls (p=0.5, 1–5 cycles) → buffer[250..255,0..5] correct; arvalid and araddr stable while stalled.
- Errors and reset: SLVERR on beat 3 of 8 → all 8 beats written and done_error=1. Separately, reset=0 for 1 cycle mid-DATA → arvalid, rready and done_valid are 0 next cycle; a new start then completes correctly.
